// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared MIPS register-file constants and types
package register_file_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   localparam int REG_ZERO = 0;
   localparam int REG_SP   = 29;
   localparam int REG_RA   = 31;

   localparam logic [31:0] SP_RESET_DEF = 32'h0000_0000;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [DATA_W_DEF-1:0] reg_data_t;

   // Power-on content of register idx; only $sp has a non-zero seed.
   function automatic reg_data_t reset_value(input int idx, input reg_data_t sp_value);
      return (idx == REG_SP) ? sp_value : '0;
   endfunction

endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - read/write port bundle between datapath and register file
interface register_file_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);

   logic              reg_write;
   logic [ADDR_W-1:0] read_reg1;
   logic [ADDR_W-1:0] read_reg2;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data1;
   logic [DATA_W-1:0] read_data2;

   modport master (
      output reg_write, read_reg1, read_reg2, write_reg, write_data,
      input  read_data1, read_data2
   );

   modport slave (
      input  reg_write, read_reg1, read_reg2, write_reg, write_data,
      output read_data1, read_data2
   );

endinterface

// File: rtl/register_file_reg_decoder.sv
// rtl/register_file_reg_decoder.sv - gate-level one-hot write-enable decoder
module reg_decoder #(
   parameter int ADDR_W = 5
) (
   input  logic                     en,
   input  logic [ADDR_W-1:0]        addr,
   output logic [(1<<ADDR_W)-1:1]   onehot
);

   // Index 0 has no output: the zero register never gets an enable.
   for (genvar i = 1; i < (1 << ADDR_W); i++) begin : g_line
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
      logic [ADDR_W-1:0] lit;

      for (genvar b = 0; b < ADDR_W; b++) begin : g_bit
         if (IDX[b]) begin : g_true
            assign lit[b] = addr[b];
         end else begin : g_comp
            assign lit[b] = ~addr[b];
         end
      end

      // en gates every line, so X on addr cannot raise an enable when en=0.
      assign onehot[i] = en & (&lit);
   end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32-entry dual-read single-write MIPS register file
module register_file
   import register_file_pkg::*;
#(
   parameter int              DATA_W   = DATA_W_DEF,
   parameter int              ADDR_W   = ADDR_W_DEF,
   parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEF),
   parameter bit              BYPASS   = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   register_file_if.slave bus
);

   localparam int NREGS = 1 << ADDR_W;

   logic [NREGS-1:1]  we;
   logic [DATA_W-1:0] regs [1:NREGS-1];
   logic [DATA_W-1:0] view [NREGS];
   logic              wr_live;

   reg_decoder #(.ADDR_W(ADDR_W)) u_dec (
      .en     (bus.reg_write),
      .addr   (bus.write_reg),
      .onehot (we)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NREGS; i++) begin
            regs[i] <= (i == REG_SP) ? SP_RESET : '0;
         end
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            if (we[i]) begin
               regs[i] <= bus.write_data;
            end
         end
      end
   end

   // Address 0 is a hard-wired zero slot in the read view.
   always_comb begin
      view[0] = '0;
      for (int i = 1; i < NREGS; i++) begin
         view[i] = regs[i];
      end
   end

   assign wr_live = bus.reg_write && (bus.write_reg != '0);

   always_comb begin
      bus.read_data1 = view[bus.read_reg1];
      if (BYPASS && wr_live && (bus.read_reg1 == bus.write_reg)) begin
         bus.read_data1 = bus.write_data;
      end
   end

   always_comb begin
      bus.read_data2 = view[bus.read_reg2];
      if (BYPASS && wr_live && (bus.read_reg2 == bus.write_reg)) begin
         bus.read_data2 = bus.write_data;
      end
   end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file, BYPASS=0 and BYPASS=1
module tb_register_file;

   localparam logic [31:0] SP = 32'h7FFF_EFFC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        reg_write = 1'b0;
   logic [4:0]  read_reg1 = '0;
   logic [4:0]  read_reg2 = '0;
   logic [4:0]  write_reg = '0;
   logic [31:0] write_data = '0;
   bit          checking = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [31:0] mdl [32];

   register_file_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
   register_file_if #(.DATA_W(32), .ADDR_W(5)) if1 ();

   assign if0.reg_write  = reg_write;
   assign if0.read_reg1  = read_reg1;
   assign if0.read_reg2  = read_reg2;
   assign if0.write_reg  = write_reg;
   assign if0.write_data = write_data;
   assign if1.reg_write  = reg_write;
   assign if1.read_reg1  = read_reg1;
   assign if1.read_reg2  = read_reg2;
   assign if1.write_reg  = write_reg;
   assign if1.write_data = write_data;

   register_file #(.SP_RESET(SP), .BYPASS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   register_file #(.SP_RESET(SP), .BYPASS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mdl[i] = (i == 29) ? SP : 32'h0;
   endtask

   // Architectural model: array of 32 words, reg 0 reads as zero.
   always @(negedge rst_n) model_reset();
   always @(posedge clk) begin
      if (rst_n !== 1'b1) model_reset();
      else if (reg_write === 1'b1 && write_reg != 5'd0) mdl[write_reg] = write_data;
   end

   function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 32'h0;
      if (byp && reg_write === 1'b1 && write_reg === a) return write_data;
      return mdl[a];
   endfunction

   always @(negedge clk) begin
      if (checking) begin
         check("cmp_b0_rd1", if0.read_data1, exp_read(read_reg1, 1'b0));
         check("cmp_b0_rd2", if0.read_data2, exp_read(read_reg2, 1'b0));
         check("cmp_b1_rd1", if1.read_data1, exp_read(read_reg1, 1'b1));
         check("cmp_b1_rd2", if1.read_data2, exp_read(read_reg2, 1'b1));
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      cycle();
      cycle();
      read_reg1 = 5'd29; read_reg2 = 5'd5;
      #1;
      check("rst_sp", if0.read_data1, SP);
      check("rst_r5", if0.read_data2, 32'h0);
      rst_n = 1'b1;
      checking = 1'b1;
      cycle();

      // Basic write to reg 8, reg 9 alongside
      read_reg1 = 5'd8; read_reg2 = 5'd9;
      reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEAD_BEEF;
      #1;
      check("basic_old", if0.read_data1, 32'h0);
      check("basic_byp", if1.read_data1, 32'hDEAD_BEEF);
      cycle();
      reg_write = 1'b0;
      #1;
      check("basic_new", if0.read_data1, 32'hDEAD_BEEF);
      check("basic_r9", if0.read_data2, 32'h0);

      // Zero register
      read_reg1 = 5'd0; read_reg2 = 5'd0;
      reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF;
      #1;
      check("zero_byp", if1.read_data1, 32'h0);
      cycle();
      reg_write = 1'b0;
      #1;
      check("zero_after", if0.read_data1, 32'h0);
      check("zero_after_b", if1.read_data2, 32'h0);

      // Write disable, then X on address/data with reg_write=0
      reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h1111_1111;
      read_reg1 = 5'd5; read_reg2 = 5'd8;
      cycle();
      reg_write = 1'b0; write_data = 32'h1234_5678;
      cycle();
      check("wdis_r5", if0.read_data1, 32'h1111_1111);
      write_reg = 'x; write_data = 'x;
      cycle();
      check("xin_r5", if0.read_data1, 32'h1111_1111);
      check("xin_r8", if1.read_data2, 32'hDEAD_BEEF);

      // Read-during-write on reg 31
      reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h1357_9BDF;
      cycle();
      read_reg1 = 5'd31; read_reg2 = 5'd31; write_data = 32'hA5A5_A5A5;
      #1;
      check("rdw_old1", if0.read_data1, 32'h1357_9BDF);
      check("rdw_old2", if0.read_data2, 32'h1357_9BDF);
      check("rdw_byp1", if1.read_data1, 32'hA5A5_A5A5);
      check("rdw_byp2", if1.read_data2, 32'hA5A5_A5A5);
      cycle();
      reg_write = 1'b0;
      #1;
      check("rdw_new", if0.read_data1, 32'hA5A5_A5A5);

      // Sweep
      for (int i = 1; i < 32; i++) begin
         reg_write = 1'b1; write_reg = 5'(i); write_data = (32'(i) << 8) | 32'(i);
         read_reg1 = 5'(i); read_reg2 = 5'(32 - i);
         cycle();
      end
      reg_write = 1'b0;
      for (int i = 1; i < 32; i++) begin
         read_reg1 = 5'(i); read_reg2 = 5'(32 - i);
         #1;
         check("sweep_rd1", if0.read_data1, (32'(i) << 8) | 32'(i));
         check("sweep_rd2", if1.read_data2, (32'(32 - i) << 8) | 32'(32 - i));
         cycle();
      end
      read_reg1 = 5'd0;
      cycle();

      // Asynchronous reset mid-cycle, write during reset is ignored
      read_reg1 = 5'd29; read_reg2 = 5'd8;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_sp", if0.read_data1, SP);
      check("arst_r8", if1.read_data2, 32'h0);
      reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hCAFE_F00D;
      cycle();
      check("arst_wr", if0.read_data2, 32'h0);
      reg_write = 1'b0;
      #2;
      rst_n = 1'b1;
      cycle();
      reg_write = 1'b1; write_reg = 5'd8; write_data = 32'h0000_0077;
      cycle();
      reg_write = 1'b0;
      #1;
      check("post_rst_wr", if0.read_data2, 32'h0000_0077);
      cycle();
      checking = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
